// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// spi_reg_slave : SPI mode-0 slave register bank, oversampled by clk.
// Macro SPI_REG_SLAVE_ID_EN turns reg0 into a read-only ID_VALUE register.
// Revision: 1.0
// ============================================================================
module spi_reg_slave #(
  parameter int         NREGS    = 16,
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sck_i,
  input  logic                  spi_scs_i,
  input  logic                  spi_sdi_i,
  output logic                  spi_sdo_o,
  output logic                  spi_sdo_oe_o,
  output logic [NREGS*8-1:0]    regs_o,
  output logic                  wr_strobe_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic                  busy_o
);

`ifdef SPI_REG_SLAVE_ID_EN
  localparam logic [7:0] REG0_RST = ID_VALUE;
`else
  // ID_VALUE only has an effect when the ID register is enabled.
  localparam logic [7:0] REG0_RST = ID_VALUE & 8'h00;
`endif

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [2:0]        scs_sync_q, scs_sync_d;
  logic [1:0]        sdi_sync_q, sdi_sync_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_in_q, shift_in_d;
  logic [7:0]        shift_out_q, shift_out_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sdo_q, sdo_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];

  logic              sck_rise, sck_fall, scs_rise, scs_fall;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] cmd_addr;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign scs_rise = scs_sync_q[1] & ~scs_sync_q[2];
  assign scs_fall = ~scs_sync_q[1] & scs_sync_q[2];
  assign byte_in  = {shift_in_q, sdi_sync_q[1]};
  assign cmd_addr = byte_in[ADDR_W-1:0];

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck_i};
    scs_sync_d  = {scs_sync_q[1:0], spi_scs_i};
    sdi_sync_d  = {sdi_sync_q[0], spi_sdi_i};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    sdo_d       = sdo_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    // A deselect in the same clk as an sck edge takes priority over it.
    if (scs_rise) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (scs_fall) begin
        state_d    = CMD;
        bit_cnt_d  = 3'd0;
        shift_in_d = 7'd0;
      end
    end else if (sck_rise) begin
      shift_in_d = byte_in[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          CMD: begin
            if (byte_in[7]) begin
              state_d = WDATA;
              addr_d  = cmd_addr;
            end else begin
              state_d     = RDATA;
              shift_out_d = regs_q[cmd_addr];
              addr_d      = cmd_addr + ADDR_W'(1);
            end
          end
          WDATA: begin
`ifdef SPI_REG_SLAVE_ID_EN
            if (addr_q != '0) begin
              regs_d[addr_q] = byte_in;
              wr_strobe_d    = 1'b1;
              wr_addr_d      = addr_q;
            end
`else
            regs_d[addr_q] = byte_in;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
`endif
            addr_d = addr_q + ADDR_W'(1);
          end
          RDATA: begin
            shift_out_d = regs_q[addr_q];
            addr_d      = addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end else if (sck_fall && state_q == RDATA) begin
      sdo_d       = shift_out_q[7];
      shift_out_d = {shift_out_q[6:0], 1'b0};
    end

    if (state_d != RDATA) sdo_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= 3'b000;
      scs_sync_q  <= 3'b111;
      sdi_sync_q  <= 2'b00;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 8'd0;
      addr_q      <= '0;
      sdo_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? REG0_RST : 8'h00;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      scs_sync_q  <= scs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      sdo_q       <= sdo_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign regs_o[8*i +: 8] = regs_q[i];
  end

  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_oe_o = ~scs_sync_q[1];
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_slave : directed scoreboard bench for spi_reg_slave.
// Revision: 1.0
// ============================================================================
module tb_spi_reg_slave;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sck = 1'b0;
  logic         scs = 1'b1;
  logic         sdi = 1'b0;
  logic         sdo, sdo_oe, wr_strobe, busy;
  logic [127:0] regs;
  logic [3:0]   wr_addr;

  always #5 clk = ~clk;

  spi_reg_slave #(.NREGS(16), .ADDR_W(4), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck_i(sck), .spi_scs_i(scs), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(sdo_oe), .regs_o(regs),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .busy_o(busy)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  got_rd[$];
  logic [7:0]  mdl [16];
  logic [11:0] e_wr;
  logic [7:0]  g_rd;
  logic [7:0]  rx;
  event        rx_ev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mdl_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
`ifdef SPI_REG_SLAVE_ID_EN
    mdl[0] = 8'hA5;
`endif
  endtask

  // Write monitor: every strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      check("strobe_expected", 128'(exp_wr.size() != 0), 128'd1);
      if (exp_wr.size() != 0) begin
        e_wr = exp_wr.pop_front();
        check("wr_addr", 128'(wr_addr), 128'(e_wr[11:8]));
        check("wr_data", 128'(regs[8*wr_addr +: 8]), 128'(e_wr[7:0]));
      end
    end
  end

  // Read monitor: every received data byte must match the next expected one.
  initial begin
    forever begin
      @(rx_ev);
      while (got_rd.size() != 0) begin
        g_rd = got_rd.pop_front();
        check("rd_expected", 128'(exp_rd.size() != 0), 128'd1);
        if (exp_rd.size() != 0) check("rd_data", 128'(g_rd), 128'(exp_rd.pop_front()));
      end
    end
  end

  task automatic spi_begin();
    @(negedge clk);
    scs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      repeat (H) @(negedge clk);
      sck = 1'b1;
      r = {r[6:0], sdo};
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    scs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wr_data(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
`ifdef SPI_REG_SLAVE_ID_EN
    if (a != 4'd0) begin
      exp_wr.push_back({a, d});
      mdl[a] = d;
    end
`else
    exp_wr.push_back({a, d});
    mdl[a] = d;
`endif
    spi_bits(d, 8, r);
  endtask

  task automatic rd_data(input logic [3:0] a);
    logic [7:0] r;
    exp_rd.push_back(mdl[a]);
    spi_bits(8'hFF, 8, r);
    got_rd.push_back(r);
    -> rx_ev;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mdl_reset();
    repeat (3) @(negedge clk);
    check("rst_regs", regs, mdl_flat());
    check("rst_strobe", 128'(wr_strobe), 128'd0);
    check("rst_wr_addr", 128'(wr_addr), 128'd0);
    check("rst_sdo", 128'(sdo), 128'd0);
    check("rst_oe", 128'(sdo_oe), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x83, 0x11, 0x22
    spi_begin();
    check("oe_selected", 128'(sdo_oe), 128'd1);
    spi_bits(8'h83, 8, rx);
    check("busy_in_txn", 128'(busy), 128'd1);
    wr_data(4'd3, 8'h11);
    wr_data(4'd4, 8'h22);
    spi_end();
    check("regs_after_wr", regs, mdl_flat());

    // Read back from address 3
    spi_begin();
    spi_bits(8'h03, 8, rx);
    rd_data(4'd3);
    rd_data(4'd4);
    spi_end();

    // Address wrap 15 -> 0
    spi_begin();
    spi_bits(8'h8F, 8, rx);
    wr_data(4'd15, 8'hAA);
    wr_data(4'd0, 8'hBB);
    spi_end();
    check("regs_after_wrap", regs, mdl_flat());

    // Abort a partial data byte
    spi_begin();
    spi_bits(8'h82, 8, rx);
    wr_data(4'd2, 8'h5C);
    spi_end();
    spi_begin();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'hFF, 5, rx);
    repeat (4) @(negedge clk);
    scs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("busy_before_deselect_seen", 128'(busy), 128'd1);
    @(posedge clk);
    #1 check("busy_after_abort", 128'(busy), 128'd0);
    repeat (8) @(negedge clk);
    check("regs_after_abort", regs, mdl_flat());
    spi_begin();
    spi_bits(8'h02, 8, rx);
    rd_data(4'd2);
    spi_end();

    // Fill the whole bank, then read it all back at minimum sck period
    spi_begin();
    spi_bits(8'h80, 8, rx);
    for (int i = 0; i < 16; i++) wr_data(4'(i), 8'(i * 17 + 3));
    spi_end();
    check("regs_full_bank", regs, mdl_flat());
    spi_begin();
    spi_bits(8'h00, 8, rx);
    for (int i = 0; i < 16; i++) rd_data(4'(i));
    spi_end();

    // Reset during the second data byte of a read
    spi_begin();
    spi_bits(8'h00, 8, rx);
    rd_data(4'd0);
    spi_bits(8'hFF, 3, rx);
    rst_n = 1'b0;
    scs   = 1'b1;
    sck   = 1'b0;
    mdl_reset();
    #1;
    check("midrst_regs", regs, mdl_flat());
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_sdo", 128'(sdo), 128'd0);
    check("midrst_oe", 128'(sdo_oe), 128'd0);
    check("midrst_strobe", 128'(wr_strobe), 128'd0);
    check("midrst_wr_addr", 128'(wr_addr), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    spi_begin();
    spi_bits(8'h85, 8, rx);
    wr_data(4'd5, 8'h77);
    spi_end();
    spi_begin();
    spi_bits(8'h05, 8, rx);
    rd_data(4'd5);
    rd_data(4'd6);
    spi_end();
    check("regs_after_midrst", regs, mdl_flat());

    repeat (20) @(negedge clk);
    check("wr_queue_drained", 128'(exp_wr.size()), 128'd0);
    check("rd_queue_drained", 128'(exp_rd.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI mode-0 slave register bank implemented in fabric and clocked by the system clock, oversampling the SPI pins. It is the responder for the SoC SPI master port (sck/scs/sdo/sdi): the core writes control bytes into the bank and reads them back. Register contents are exposed as a flat bus for board-level logic such as display, LEDs and test hooks.

## Interface
- NREGS, 16: number of 8-bit registers; power of two, 2..128.
- ADDR_W, 4: log2(NREGS).
- ID_VALUE, 8'hA5: register 0 content when SPI_REG_SLAVE_ID_EN is defined.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck_i  in  1  SPI clock from master, asynchronous to clk.
- spi_scs_i  in  1  chip select, active low, asynchronous.
- spi_sdi_i  in  1  master-out data.
- spi_sdo_o  out  1  slave-out data.
- spi_sdo_oe_o  out  1  high while selected, for an external tristate.
- regs_o  out  NREGS*8  register bank; reg[i] occupies bits [8i+7:8i].
- wr_strobe_o  out  1  one-clk pulse per committed write.
- wr_addr_o  out  ADDR_W  address of the last committed write.
- busy_o  out  1  high while a transaction is in progress (state not IDLE).

## Operation
- Synchronisation: sck, scs and sdi each pass through 2-flop synchronisers. Edges are detected on the synchronised sck/scs against a third registered copy.
- Protocol: mode 0, MSB first.
  - First byte is the command: bit7 = 1 for write, 0 for read. Bits[ADDR_W-1:0] are the start address; remaining bits are ignored.
  - Every following byte is data. The address auto-increments after each data byte and wraps modulo NREGS.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD on the scs falling edge; bit counter and shift register cleared.
  - CMD: sdi is shifted on each sck rising edge. On the 8th rising edge, latch the address and go to WDATA or RDATA.
  - WDATA: on each 8th rising edge, reg[addr] <= shifted byte, wr_strobe_o = 1 for one clk, wr_addr_o <= addr, addr <= addr+1.
  - RDATA:
    - On entry, and at each 8th rising edge, the shift-out register loads a snapshot of reg[addr] and addr <= addr+1.
    - The MSB is driven on the next sck falling edge, and one bit is shifted per sck falling edge after that.
  - Any state -> IDLE on the scs rising edge. A partial byte is discarded and nothing is written.
- spi_sdo_o is 0 in IDLE, CMD and WDATA. spi_sdo_oe_o = synchronised ~scs.
- A scs rising edge and an sck edge in the same clk: scs wins and the sck edge is ignored.

## Timing
- Reset values: regs_o all 0 (reg0 = ID_VALUE with macro), wr_strobe_o 0, wr_addr_o 0, spi_sdo_o 0, spi_sdo_oe_o 0, busy_o 0, state IDLE.
- Reset asserted mid-transaction: immediate return to the reset state. The bank is cleared.
- Input constraint: sck high and low phases each at least 4 clk periods. scs setup before the first sck rising edge and hold after the last sck falling edge, each at least 4 clk.
- Latency:
  - regs_o and wr_strobe_o update 3 clk edges after the synchronisers first see the 8th sck high of a data byte.
  - spi_sdo_o changes 3 clk edges after the synchronisers see an sck falling edge. This is within half an sck period under the constraint above.
- busy_o rises 3 clk after scs falls and drops 3 clk after scs rises.

## Configuration
- SPI_REG_SLAVE_ID_EN:
  - Defined: reg0 is read-only and holds ID_VALUE. A write to address 0 is dropped: no wr_strobe_o, but the address still increments.
  - Undefined: reg0 is an ordinary read/write register that resets to 0.

## Test plan
- Write 0x83, 0x11, 0x22 -> reg3 = 0x11, reg4 = 0x22; two wr_strobe_o pulses with wr_addr_o 3 then 4.
- After that write, read 0x03 followed by 2 dummy bytes -> sdo returns 0x11, 0x22.
- Wrap: write 0x8F, 0xAA, 0xBB with NREGS=16 -> reg15 = 0xAA, reg0 = 0xBB. With SPI_REG_SLAVE_ID_EN, reg0 stays 0xA5 and only one strobe occurs.
- Abort: write 0x82, then 5 data bits, then scs high -> reg2 unchanged, no strobe, busy_o low 3 clk later. A following read of reg2 returns the old value.
- Reset mid-read (rst_n low during the 2nd data byte) -> all outputs at reset values at once. The next transaction decodes correctly from the command byte.
- Minimum sck period (8 clk): 16-byte read of the full bank matches the written pattern bit-exactly.
